// File: rtl/voting_pkg.sv
// voting_pkg
//   Shared types and constants for the voting tally unit.
//   state_t : session FSM states
//   CMP_*   : one-hot compare encoding, [2]=greater [1]=equal [0]=less
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/voting_compare.sv
// voting_compare
//   Combinational magnitude compare of two unsigned W-bit values with a
//   one-hot result.
//   a, b : operands (W bits)
//   y    : CMP_GT if a>b, CMP_EQ if a==b, CMP_LT if a<b
module voting_compare
  import voting_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [2:0]   y
);

  always_comb begin
    y = CMP_LT;
    if (a > b) begin
      y = CMP_GT;
    end else if (a == b) begin
      y = CMP_EQ;
    end
  end

endmodule

// File: rtl/voting_tally_unit.sv
// voting_tally_unit
//   Runs one voting session: collects one ballot per voter into
//   per-candidate counters, then scans the counters for the winner and
//   compares the winner's count with a threshold latched at close.
//   clk, rst          : clock, synchronous active-high reset
//   start, close      : open a session (IDLE/DONE) / end it (OPEN)
//   vote_valid, voter_id, cand_id : ballot input
//   threshold         : compare value, sampled with close
//   open              : session accepting ballots
//   accept, reject    : one-cycle ballot outcome, the cycle after vote_valid
//   result_valid      : results below are valid (DONE)
//   winner, winner_count, tie, cmp : session result, zero outside DONE
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   OPEN  | accepting ballots until close
//   TALLY | scanning counter k = 0..N_CAND-1, one per cycle
//   DONE  | result held until the next start
module voting_tally_unit
  import voting_pkg::*;
#(
  parameter  int N_VOTERS = 8,
  parameter  int N_CAND   = 4,
  localparam int CNT_W    = $clog2(N_VOTERS + 1),
  localparam int ID_W     = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1,
  localparam int CID_W    = (N_CAND > 1) ? $clog2(N_CAND) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vote_valid,
  input  logic [ID_W-1:0]  voter_id,
  input  logic [CID_W-1:0] cand_id,
  input  logic             close,
  input  logic [CNT_W-1:0] threshold,
  output logic             open,
  output logic             accept,
  output logic             reject,
  output logic             result_valid,
  output logic [CID_W-1:0] winner,
  output logic [CNT_W-1:0] winner_count,
  output logic             tie,
  output logic [2:0]       cmp
);

  state_t                         state_q, state_d;
  logic [N_CAND-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_VOTERS-1:0]            voted_q, voted_d;
  logic [CNT_W-1:0]               thr_q, thr_d;
  logic                           accept_q, accept_d;
  logic                           reject_q, reject_d;
  logic [CID_W-1:0]               scan_q, scan_d;
  logic [CNT_W-1:0]               best_q, best_d;
  logic [CID_W-1:0]               winner_q, winner_d;
  logic                           tie_q, tie_d;

  logic                           already_voted;
  logic                           ballot_ok;
  logic [CNT_W-1:0]               scan_cnt;
  logic [2:0]                     cmp_raw;

  // Per-voter / per-candidate loops instead of direct indexing so that
  // out-of-range IDs never address past the end of the arrays.
  always_comb begin
    already_voted = 1'b0;
    for (int i = 0; i < N_VOTERS; i++) begin
      if (voter_id == ID_W'(i)) begin
        already_voted = voted_q[i];
      end
    end
    ballot_ok = (int'(voter_id) < N_VOTERS) && (int'(cand_id) < N_CAND) &&
                !already_voted;
  end

  assign scan_cnt = cnt_q[scan_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    voted_d  = voted_q;
    thr_d    = thr_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    scan_d   = scan_q;
    best_d   = best_q;
    winner_d = winner_q;
    tie_d    = tie_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = OPEN;
          cnt_d    = '0;
          voted_d  = '0;
          scan_d   = '0;
          best_d   = '0;
          winner_d = '0;
          tie_d    = 1'b0;
        end
      end

      OPEN: begin
        if (vote_valid) begin
          if (ballot_ok) begin
            accept_d = 1'b1;
            for (int i = 0; i < N_VOTERS; i++) begin
              if (voter_id == ID_W'(i)) voted_d[i] = 1'b1;
            end
            for (int c = 0; c < N_CAND; c++) begin
              if (cand_id == CID_W'(c)) cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end else begin
            reject_d = 1'b1;
          end
        end
        // A ballot arriving with close is still counted: the scan only
        // starts on the following cycle, after the counter update lands.
        if (close) begin
          state_d = TALLY;
          thr_d   = threshold;
          scan_d  = '0;
        end
      end

      TALLY: begin
        if (scan_q == '0) begin
          best_d   = scan_cnt;
          winner_d = '0;
          tie_d    = 1'b0;
        end else if (scan_cnt > best_q) begin
          best_d   = scan_cnt;
          winner_d = scan_q;
          tie_d    = 1'b0;
        end else if (scan_cnt == best_q) begin
          tie_d = 1'b1;
        end

        if (scan_q == CID_W'(N_CAND - 1)) begin
          state_d = DONE;
        end else begin
          scan_d = scan_q + CID_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      voted_q  <= '0;
      thr_q    <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      scan_q   <= '0;
      best_q   <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      voted_q  <= voted_d;
      thr_q    <= thr_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      scan_q   <= scan_d;
      best_q   <= best_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  voting_compare #(.W(CNT_W)) u_cmp (
    .a (best_q),
    .b (thr_q),
    .y (cmp_raw)
  );

  // Scan registers hold partial results during TALLY; only DONE exposes them.
  assign open         = (state_q == OPEN);
  assign result_valid = (state_q == DONE);
  assign accept       = accept_q;
  assign reject       = reject_q;
  assign winner       = result_valid ? winner_q : '0;
  assign winner_count = result_valid ? best_q   : '0;
  assign tie          = result_valid ? tie_q    : 1'b0;
  assign cmp          = result_valid ? cmp_raw  : 3'b000;

endmodule

// File: tb/tb_voting_tally_unit.sv
// Bench for voting_tally_unit. N_VOTERS=9 gives a 4-bit voter ID so that
// IDs 9..15 are out of range.
module tb_voting_tally_unit;

  localparam int NV    = 9;
  localparam int NC    = 4;
  localparam int CNT_W = $clog2(NV + 1);
  localparam int ID_W  = $clog2(NV);
  localparam int CID_W = $clog2(NC);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             vote_valid;
  logic [ID_W-1:0]  voter_id;
  logic [CID_W-1:0] cand_id;
  logic             close;
  logic [CNT_W-1:0] threshold;
  logic             open;
  logic             accept;
  logic             reject;
  logic             result_valid;
  logic [CID_W-1:0] winner;
  logic [CNT_W-1:0] winner_count;
  logic             tie;
  logic [2:0]       cmp;

  voting_tally_unit #(.N_VOTERS(NV), .N_CAND(NC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vote_valid   (vote_valid),
    .voter_id     (voter_id),
    .cand_id      (cand_id),
    .close        (close),
    .threshold    (threshold),
    .open         (open),
    .accept       (accept),
    .reject       (reject),
    .result_valid (result_valid),
    .winner       (winner),
    .winner_count (winner_count),
    .tie          (tie),
    .cmp          (cmp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain vote counts and a who-has-voted list.
  int m_cnt[NC];
  bit m_voted[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    for (int v = 0; v < NV; v++) m_voted[v] = 1'b0;
  endtask

  task automatic model_ballot(input int vid, input int cid, output bit ok);
    ok = (vid < NV) && (cid < NC) && !m_voted[vid];
    if (ok) begin
      m_voted[vid] = 1'b1;
      m_cnt[cid]   = m_cnt[cid] + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; vote_valid = 1'b0; close = 1'b0;
    voter_id = '0; cand_id = '0; threshold = '0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    n_vec++;
    if (open !== 1'b1 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_open: open=%b result_valid=%b, want open=1 result_valid=0",
               open, result_valid);
    end
  endtask

  task automatic cast(input int vid, input int cid);
    bit ok;
    vote_valid = 1'b1;
    voter_id   = ID_W'(vid);
    cand_id    = CID_W'(cid);
    model_ballot(vid, cid, ok);
    tick();
    vote_valid = 1'b0;
    n_vec++;
    if (accept !== ok || reject !== !ok) begin
      n_err++;
      $display("FAIL ballot v%0d c%0d: accept=%b reject=%b, want accept=%b reject=%b",
               vid, cid, accept, reject, ok, !ok);
    end
  endtask

  // Close (optionally with a ballot on the same cycle), wait for the
  // result with a bounded wait, and check it against the model.
  task automatic close_session(input int thr, input bit with_vote,
                               input int vid, input int cid);
    bit ok;
    int cycles;
    int best, win, n_best;
    logic [2:0] exp_cmp;
    close     = 1'b1;
    threshold = CNT_W'(thr);
    if (with_vote) begin
      vote_valid = 1'b1;
      voter_id   = ID_W'(vid);
      cand_id    = CID_W'(cid);
      model_ballot(vid, cid, ok);
    end
    tick();
    close      = 1'b0;
    vote_valid = 1'b0;
    if (with_vote) begin
      n_vec++;
      if (accept !== ok || reject !== !ok) begin
        n_err++;
        $display("FAIL close_ballot: accept=%b reject=%b, want accept=%b reject=%b",
                 accept, reject, ok, !ok);
      end
    end
    n_vec++;
    if (open !== 1'b0) begin
      n_err++;
      $display("FAIL closed_open: open=%b, want 0", open);
    end

    cycles = 1;
    while (result_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    n_vec++;
    if (cycles != NC + 1) begin
      n_err++;
      $display("FAIL latency: result after %0d cycles, want %0d", cycles, NC + 1);
    end

    best = -1; win = 0; n_best = 0;
    for (int c = 0; c < NC; c++) if (m_cnt[c] > best) begin best = m_cnt[c]; win = c; end
    for (int c = 0; c < NC; c++) if (m_cnt[c] == best) n_best++;
    exp_cmp = (best > thr) ? 3'b100 : (best == thr) ? 3'b010 : 3'b001;

    n_vec++;
    if (winner !== CID_W'(win) || winner_count !== CNT_W'(best) ||
        tie !== (n_best > 1) || cmp !== exp_cmp) begin
      n_err++;
      $display("FAIL result: winner=%0d count=%0d tie=%b cmp=%b, want winner=%0d count=%0d tie=%b cmp=%b",
               winner, winner_count, tie, cmp, win, best, n_best > 1, exp_cmp);
    end

    // DONE ignores close and ballots; the result must hold.
    close = 1'b1; vote_valid = 1'b1; voter_id = '0; cand_id = '0;
    tick();
    close = 1'b0; vote_valid = 1'b0;
    n_vec++;
    if (result_valid !== 1'b1 || winner !== CID_W'(win) || winner_count !== CNT_W'(best) ||
        accept !== 1'b0 || reject !== 1'b0) begin
      n_err++;
      $display("FAIL done_hold: rv=%b winner=%0d count=%0d acc=%b rej=%b, want rv=1 winner=%0d count=%0d acc=0 rej=0",
               result_valid, winner, winner_count, accept, reject, win, best);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({open, accept, reject, result_valid, winner, winner_count, tie, cmp} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {open, accept, reject, result_valid, winner, winner_count, tie, cmp});
    end
  endtask

  task automatic test_majority();
    start_session();
    for (int v = 0; v < 5; v++) cast(v, 2);
    cast(5, 1);
    cast(6, 1);
    close_session(4, 1'b0, 0, 0);
  endtask

  task automatic test_double_vote();
    start_session();
    cast(3, 0);
    cast(3, 1);
    close_session(1, 1'b0, 0, 0);
  endtask

  task automatic test_tie();
    start_session();
    cast(0, 1); cast(1, 3); cast(2, 1); cast(3, 3);
    close_session(2, 1'b0, 0, 0);
  endtask

  task automatic test_out_of_range_and_idle();
    do_reset();
    vote_valid = 1'b1; voter_id = ID_W'(1); cand_id = CID_W'(1);
    tick();
    vote_valid = 1'b0;
    n_vec++;
    if (accept !== 1'b0 || reject !== 1'b0 || open !== 1'b0) begin
      n_err++;
      $display("FAIL idle_vote: accept=%b reject=%b open=%b, want 0 0 0", accept, reject, open);
    end
    close = 1'b1;
    tick();
    close = 1'b0;
    n_vec++;
    if (open !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_close: open=%b rv=%b, want 0 0", open, result_valid);
    end
    start_session();
    cast(9, 0);
    cast(15, 2);
    cast(1, 1);
    close_session(1, 1'b0, 0, 0);
  endtask

  task automatic test_vote_with_close();
    start_session();
    close_session(3, 1'b1, 0, 0);
  endtask

  task automatic test_reset_in_tally();
    start_session();
    cast(0, 2); cast(1, 2);
    close = 1'b1; threshold = CNT_W'(1);
    tick();
    close = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    n_vec++;
    if ({open, accept, reject, result_valid, winner, winner_count, tie, cmp} !== '0) begin
      n_err++;
      $display("FAIL tally_reset: got %b, want all zero",
               {open, accept, reject, result_valid, winner, winner_count, tie, cmp});
    end
    start_session();
    close_session(0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    // Result from the previous session is showing; start must clear it at once.
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    n_vec++;
    if (open !== 1'b1 || result_valid !== 1'b0 || winner !== '0 ||
        winner_count !== '0 || tie !== 1'b0 || cmp !== 3'b000) begin
      n_err++;
      $display("FAIL restart_clear: open=%b rv=%b winner=%0d count=%0d tie=%b cmp=%b, want 1 0 0 0 0 000",
               open, result_valid, winner, winner_count, tie, cmp);
    end
    cast(0, 3);
    // start while OPEN is ignored: voter 0 must still be marked as voted.
    start = 1'b1;
    tick();
    start = 1'b0;
    cast(0, 3);
    cast(4, 3);
    close_session(2, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      int nb;
      start_session();
      nb = $urandom_range(0, 14);
      for (int b = 0; b < nb; b++) cast($urandom_range(0, 15), $urandom_range(0, NC - 1));
      close_session($urandom_range(0, NV), $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, NC - 1));
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_double_vote();
    test_tie();
    test_out_of_range_and_idle();
    test_vote_with_close();
    test_reset_in_tally();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
